rf_dump: RTL and testbench
==========================

RF_DUMP -- requirements
Module: rf_dump

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50_000_000, meaning the number of clk cycles each register is held on the display.
REQ-002 The block SHALL have parameter RF_DEPTH, default 32, meaning the number of register-file entries scanned (indices 0..RF_DEPTH-1).
REQ-003 Port clk, input, 1 bit: the single clock; every flop SHALL be rising-edge.
REQ-004 Port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port sw_i, input, 16 bits: board switches; sw_i[1]=1 selects debug/dump mode, sw_i[2]=1 pauses the scan, sw_i[3] is the single-step switch.
REQ-006 Port rf_addr, output, 5 bits: read address driven into the register-file read port.
REQ-007 Port rf_data, input, 32 bits: combinational read data returned by the register file for rf_addr.
REQ-008 Port disp_addr, output, 5 bits: index of the register currently displayed.
REQ-009 Port disp_data, output, 32 bits: captured value of register disp_addr.
REQ-010 Port dump_valid, output, 1 bit: one-cycle pulse when disp_addr/disp_data update.
REQ-011 Port dump_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, FETCH, CAPTURE and HOLD, held in a registered state variable.
REQ-013 In IDLE with sw_i[1]=1, the FSM SHALL go to FETCH on the next edge, with the scan index reset to 0.
REQ-014 FETCH SHALL drive rf_addr=index for one cycle, then go to CAPTURE.
REQ-015 CAPTURE SHALL register disp_data<=rf_data and disp_addr<=index, pulse dump_valid for that edge only, clear the tick counter and go to HOLD.
REQ-016 In HOLD, the tick counter SHALL increment each cycle unless sw_i[2]=1, in which case the counter freezes and the display is unchanged.
REQ-017 When the counter reaches TICK_DIV-1, or on a detected rising edge of sw_i[3], HOLD SHALL advance the index and go to FETCH.
REQ-018 Index advance SHALL wrap from RF_DEPTH-1 to 0.
REQ-019 Latency from a HOLD exit to the dump_valid pulse SHALL be exactly 2 cycles.
REQ-020 sw_i[3] SHALL be synchronized through two flops and edge-detected.
REQ-021 A sw_i[3] edge while sw_i[2]=1 SHALL still step the scan; this is the single-step path.
REQ-022 The tick counter SHALL be $clog2(TICK_DIV) bits wide and SHALL never exceed TICK_DIV-1.
REQ-023 sw_i[1] falling in any state SHALL force IDLE on the next edge, with dump_busy=0 and no dump_valid pulse.
REQ-024 After leaving debug mode, disp_addr and disp_data SHALL retain their last values.
REQ-025 rf_addr SHALL equal the index in every state (it is stable during HOLD) and SHALL be 0 in IDLE.
REQ-026 The block SHALL never write the register file; it is read-only.

Reset
REQ-027 While rstn=0, the block SHALL asynchronously force state=IDLE, index=0, the tick counter to 0, rf_addr=0, disp_addr=0, disp_data=0, dump_valid=0, dump_busy=0, and the step synchronizer to 0.
REQ-028 Reset asserted mid-scan SHALL abandon the scan; after release, the scan SHALL restart at index 0 if sw_i[1]=1.

Configuration
REQ-029 With RF_DUMP_SKIP_ZERO_EN defined, a CAPTURE with rf_data==0 SHALL produce no dump_valid pulse and no display update, and SHALL go directly to FETCH of the next index.
REQ-030 With RF_DUMP_SKIP_ZERO_EN defined and every register zero, the block SHALL cycle continuously without hanging and with dump_valid held at 0.
REQ-031 Without RF_DUMP_SKIP_ZERO_EN, every index SHALL be displayed, including zero-valued registers.

Structure
REQ-032 The state enum, the RF_DEPTH default and the switch bit indices (DBG_SW=1, PAUSE_SW=2, STEP_SW=3) SHALL live in the shared package rf_dump_pkg.
REQ-033 The synchronizer and edge detector SHALL be the sub-module sw_edge_det, instanced once for sw_i[3].

Verification
REQ-034 Scenario: TICK_DIV=4, RF loaded rf[i]=i, sw_i[1]=1 -> dump_valid every 7 cycles, with disp_addr 0,1,2,...,31 then 0 and disp_data equal to disp_addr.
REQ-035 Scenario: sw_i[2]=1 during HOLD at index 5 for 20 cycles -> disp_addr stays 5 and there is no dump_valid; release -> advance resumes from the frozen count.
REQ-036 Scenario: paused at index 7, single sw_i[3] pulse -> exactly one dump_valid with disp_addr=8.
REQ-037 Scenario: sw_i[1] dropped in FETCH at index 9 -> IDLE next edge, dump_busy=0, disp_addr still 8; re-enable -> scan restarts at 0.
REQ-038 Scenario: rstn pulsed low mid-CAPTURE -> all outputs 0 immediately, without waiting for clk.
REQ-039 Scenario: RF_DUMP_SKIP_ZERO_EN defined with rf[0..3]=0, rf[4]=0xDEADBEEF -> first dump_valid shows disp_addr=4, disp_data=0xDEADBEEF.

Source files
------------

// File: rtl/rf_dump_pkg.sv
// Purpose: shared types and constants for the register-file dump viewer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, default scan depth, switch bit positions,
// fixed port widths and the wrapping index-advance helper.
package rf_dump_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int RF_DEPTH_DEF = 32;

  // Board switch bit positions within sw_i.
  localparam int DBG_SW   = 1;
  localparam int PAUSE_SW = 2;
  localparam int STEP_SW  = 3;

  localparam int IDX_W  = 5;
  localparam int DATA_W = 32;
  localparam int SW_W   = 16;

  // Next scan index, wrapping from depth-1 back to 0.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                   input int               depth);
    if (int'(idx) >= depth - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rf_dump_sw_edge_det.sv
// Purpose: two-flop synchronizer plus rising-edge detector for a slow switch.
// Latency: rise asserts in the second cycle after din rises (synchronizer depth).
// Backpressure: none; rise is a single-cycle pulse per rising edge of din.
//
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset, clears all three flops
//   din  - asynchronous switch input
//   rise - one-cycle pulse on each synchronized 0->1 transition of din
module sw_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      last  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      last  <= sync2;
    end
  end

  // Driven purely from flops, so the pulse is glitch-free.
  assign rise = sync2 & ~last;

endmodule

// File: rtl/rf_dump.sv
// Purpose: debug viewer that walks a register file and shows one entry at a time.
// Latency: 2 cycles from leaving HOLD to the dump_valid pulse; hold lasts TICK_DIV+1 cycles.
// Backpressure: none; sw_i[2] freezes the hold timer, sw_i[3] rising edge steps immediately.
//
// Build option: define RF_DUMP_SKIP_ZERO_EN to skip zero-valued entries
// (no pulse, no display update, straight on to the next index).
//
// Ports:
//   clk        - rising-edge clock
//   rstn       - asynchronous active-low reset
//   sw_i       - board switches: [1] debug/dump mode, [2] pause, [3] single step
//   rf_addr    - register-file read address (equals scan index, 0 in IDLE)
//   rf_data    - combinational register-file read data for rf_addr
//   disp_addr  - index of the register currently displayed
//   disp_data  - captured value of register disp_addr
//   dump_valid - one-cycle pulse when disp_addr/disp_data update
//   dump_busy  - high whenever the FSM is outside IDLE
module rf_dump
  import rf_dump_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int RF_DEPTH = RF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [SW_W-1:0]   sw_i,
  output logic [IDX_W-1:0]  rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic [IDX_W-1:0]  disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              dump_valid,
  output logic              dump_busy
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick_done;
  logic             step;
  logic             dbg;
  logic             pause;
  logic             capture_skip;
  logic             unused_sw;

  assign dbg      = sw_i[DBG_SW];
  assign pause    = sw_i[PAUSE_SW];
  assign idx_next = next_index(idx, RF_DEPTH);

  // Remaining switches are board inputs this block does not use.
  assign unused_sw = ^{sw_i[SW_W-1:STEP_SW+1], sw_i[0]};

  sw_edge_det u_step_det (
    .clk  (clk),
    .rstn (rstn),
    .din  (sw_i[STEP_SW]),
    .rise (step)
  );

`ifdef RF_DUMP_SKIP_ZERO_EN
  assign capture_skip = (rf_data == '0);
`else
  assign capture_skip = 1'b0;
`endif

  // Single FSM with registered outputs. The terminal count is latched into
  // tick_done so the HOLD exit decision comes straight from a flop; the
  // counter itself never exceeds TICK_DIV-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      idx        <= '0;
      rf_addr    <= '0;
      tick_cnt   <= '0;
      tick_done  <= 1'b0;
      disp_addr  <= '0;
      disp_data  <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
    end else begin
      dump_valid <= 1'b0;
      if (!dbg) begin
        // Leaving debug mode abandons the scan; the display keeps its value.
        state     <= IDLE;
        idx       <= '0;
        rf_addr   <= '0;
        tick_cnt  <= '0;
        tick_done <= 1'b0;
        dump_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state     <= FETCH;
            idx       <= '0;
            rf_addr   <= '0;
            dump_busy <= 1'b1;
          end

          FETCH: begin
            // rf_addr already equals idx; give the read port one cycle.
            state <= CAPTURE;
          end

          CAPTURE: begin
            if (capture_skip) begin
              idx     <= idx_next;
              rf_addr <= idx_next;
              state   <= FETCH;
            end else begin
              disp_data  <= rf_data;
              disp_addr  <= idx;
              dump_valid <= 1'b1;
              tick_cnt   <= '0;
              tick_done  <= 1'b0;
              state      <= HOLD;
            end
          end

          HOLD: begin
            // A step edge advances even while paused.
            if (step || (!pause && tick_done)) begin
              idx     <= idx_next;
              rf_addr <= idx_next;
              state   <= FETCH;
            end else if (!pause) begin
              if (tick_cnt == CNT_LAST) begin
                tick_done <= 1'b1;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rf_dump.sv
`timescale 1ns/1ps
module tb_rf_dump;

  localparam int TD        = 4;
  localparam int DEPTH     = 32;
  localparam int PERIOD    = 7;           // pulse spacing with TICK_DIV=4
  localparam int START_LAT = 3;           // IDLE -> FETCH -> CAPTURE -> pulse
  localparam int SKIP_COST = 2;           // a skipped entry costs FETCH + CAPTURE
  localparam int HOLD_CYC  = PERIOD - 2;  // HOLD part of the period

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] sw;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  disp_addr;
  logic [31:0] disp_data;
  logic        dump_valid;
  logic        dump_busy;

  logic [31:0] rf [DEPTH];
  int tests = 0;
  int fails = 0;

  assign rf_data = rf[rf_addr];

  always #5 clk = ~clk;

  rf_dump #(.TICK_DIV(TD), .RF_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sw_i       (sw),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .dump_valid (dump_valid),
    .dump_busy  (dump_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: next index that will actually be shown, starting at 'start'.
  function automatic int shown_from(input int start, output int skipped);
    int i = start;
    skipped = 0;
`ifdef RF_DUMP_SKIP_ZERO_EN
    while (rf[i] == 32'h0 && skipped < DEPTH) begin
      i = (i + 1) % DEPTH;
      skipped++;
    end
`endif
    return i;
  endfunction

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dump_valid !== 1'b1 && n < budget);
  endtask

  // Waits for a pulse, checks its timing and content, then checks it is one cycle wide.
  task automatic expect_pulse(input string tag, input int lat, input int idx);
    int n;
    wait_pulse(lat + 20, n);
    check({tag, " latency"}, n, lat);
    check({tag, " disp_addr"}, disp_addr, idx);
    check({tag, " disp_data"}, disp_data, rf[idx]);
    check({tag, " rf_addr"}, rf_addr, idx);
    @(negedge clk);
    check({tag, " pulse width"}, dump_valid, 1'b0);
  endtask

  task automatic count_pulses(input int cycles, output int cnt, output int last_addr);
    cnt = 0;
    last_addr = -1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (dump_valid === 1'b1) begin
        cnt++;
        last_addr = disp_addr;
      end
    end
  endtask

  initial begin
    int sk;
    int cur;
    int cnt;
    int addr;

    for (int i = 0; i < DEPTH; i++) rf[i] = $urandom | 32'h1;
    rf[3] = 32'h0;  // a zero-valued entry is still displayed in the default build
`ifdef RF_DUMP_SKIP_ZERO_EN
    for (int i = 0; i < 4; i++) rf[i] = 32'h0;
    rf[4] = 32'hDEADBEEF;
`endif

    // Reset state, with random noise on the switches this block ignores.
    rstn = 1'b0;
    sw   = 16'($urandom) & 16'hFFF1;
    repeat (2) @(negedge clk);
    check("rst rf_addr", rf_addr, 0);
    check("rst disp_addr", disp_addr, 0);
    check("rst disp_data", disp_data, 0);
    check("rst dump_valid", dump_valid, 0);
    check("rst dump_busy", dump_busy, 0);
    sw[1] = 1'b1;
    @(negedge clk);
    check("rst holds idle", dump_busy, 0);

    // Full scan 0..31 then wrap to 0.
    rstn = 1'b1;
    cur = shown_from(0, sk);
    expect_pulse("first", START_LAT + SKIP_COST * sk, cur);
    check("busy in scan", dump_busy, 1);
    for (int k = 0; k < DEPTH; k++) begin
      cur = shown_from((cur + 1) % DEPTH, sk);
      expect_pulse("scan", PERIOD - 1 + SKIP_COST * sk, cur);
    end

    // Advance to index 5, then pause two cycles into its hold.
    for (int k = 0; k < DEPTH && cur != 5; k++) begin
      cur = shown_from((cur + 1) % DEPTH, sk);
      expect_pulse("to5", PERIOD - 1 + SKIP_COST * sk, cur);
    end
    @(negedge clk);
    sw[2] = 1'b1;
    count_pulses(20, cnt, addr);
    check("pause pulses", cnt, 0);
    check("pause disp_addr", disp_addr, 5);
    check("pause rf_addr", rf_addr, 5);
    sw[2] = 1'b0;
    cur = shown_from(6, sk);
    expect_pulse("resume", PERIOD - 2 + SKIP_COST * sk, cur);
    cur = shown_from(7, sk);
    expect_pulse("idx7", PERIOD - 1 + SKIP_COST * sk, cur);

    // Paused at 7: one step pulse gives exactly one display of 8.
    sw[2] = 1'b1;
    repeat (3) @(negedge clk);
    sw[3] = 1'b1;
    repeat (3) @(negedge clk);
    sw[3] = 1'b0;
    count_pulses(25, cnt, addr);
    check("step pulses", cnt, 1);
    check("step addr", addr, 8);
    check("step data", disp_data, rf[8]);

    // Unpause; the scan reaches FETCH of 9 after the hold, then drop debug mode.
    sw[2] = 1'b0;
    repeat (HOLD_CYC) @(negedge clk);
    check("fetch9 rf_addr", rf_addr, 9);
    check("fetch9 busy", dump_busy, 1);
    sw[1] = 1'b0;
    @(negedge clk);
    check("drop busy", dump_busy, 0);
    check("drop rf_addr", rf_addr, 0);
    check("drop valid", dump_valid, 0);
    check("drop disp_addr", disp_addr, 8);
    check("drop disp_data", disp_data, rf[8]);
    count_pulses(10, cnt, addr);
    check("idle pulses", cnt, 0);

    // Re-enable: restart from 0.
    sw[1] = 1'b1;
    cur = shown_from(0, sk);
    expect_pulse("restart", START_LAT + SKIP_COST * sk, cur);

    // Asynchronous reset while in CAPTURE.
    repeat (PERIOD - 2) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("arst rf_addr", rf_addr, 0);
    check("arst disp_addr", disp_addr, 0);
    check("arst disp_data", disp_data, 0);
    check("arst dump_valid", dump_valid, 0);
    check("arst dump_busy", dump_busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    cur = shown_from(0, sk);
    expect_pulse("post-reset", START_LAT + SKIP_COST * sk, cur);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
